// File: rtl/s2p_pkg.sv
// Shared types and sizing for the serial-to-parallel receiver.
package s2p_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned FIFO_DEPTH = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } s2p_state_e;

endpackage

// File: rtl/s2p_fifo2.sv
// Two-entry first-in first-out buffer holding assembled words; head is always on data_o.
module s2p_fifo2
    import s2p_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_q;
    logic [PTR_W-1:0]  wr_q;
    logic [PTR_W:0]    cnt_q;
    logic              do_push;
    logic              do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
    assign data_o  = mem_q[rd_q];

    // A push into a full buffer is only taken when a pop frees a slot in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/serial2parallel.sv
// Framed serial receiver: assembles MSB-first frames into words and queues them in a 2-entry FIFO.
module serial2parallel
    import s2p_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_start,
    input  logic              serial_out,
    input  logic              serial_end,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output logic              overflow
);

    localparam int unsigned      CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

    s2p_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // The final bit comes straight from serial_out, so only DATA_W-1 bits are held.
    logic [DATA_W-2:0] shift_q, shift_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] word;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;

    assign word = {shift_q, serial_out};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        err_d   = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (serial_start) begin
                    if (serial_end) begin
                        err_d = 1'b1;
                    end else begin
                        shift_d = (DATA_W-1)'(serial_out);
                        cnt_d   = CNT_W'(1);
                        state_d = RECV;
                    end
                end
            end
            RECV: begin
                if (serial_start) begin
                    err_d = 1'b1;
                    if (serial_end) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        shift_d = (DATA_W-1)'(serial_out);
                        cnt_d   = CNT_W'(1);
                    end
                end else begin
                    shift_d = word[DATA_W-2:0];
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        push    = serial_end;
                        err_d   = !serial_end;
                    end else if (serial_end) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign ovf_d     = push && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign frame_err = err_q;
    assign overflow  = ovf_q;

    s2p_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (word),
        .pop_i       (pop),
        .data_o      (out_data),
        .full_o      (full),
        .empty_o     (empty)
    );

endmodule

// File: tb/tb_serial2parallel.sv
// Scoreboard bench for serial2parallel: directed framing cases followed by randomized traffic.
module tb_serial2parallel;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         serial_start;
    logic         serial_out;
    logic         serial_end;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         frame_err;
    logic         overflow;

    always #5 clk = ~clk;

    serial2parallel #(
        .DATA_W (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_start (serial_start),
        .serial_out   (serial_out),
        .serial_end   (serial_end),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .frame_err    (frame_err),
        .overflow     (overflow)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned n_err_dut = 0;
    int unsigned n_ovf_dut = 0;
    int unsigned n_pop_dut = 0;

    // Intent attached by the stimulus to the bit currently on the inputs.
    logic         mark_push;
    logic         mark_err;
    logic [W-1:0] mark_word;

    logic [W-1:0] model[$];
    logic         err_pend;
    logic         ovf_pend;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        err_pend = 1'b0;
        ovf_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_valid", W'(out_valid), '0);
                chk("rst_data", out_data, '0);
                chk("rst_err", W'(frame_err), '0);
                chk("rst_ovf", W'(overflow), '0);
                model.delete();
                err_pend = 1'b0;
                ovf_pend = 1'b0;
            end else begin
                chk("out_valid", W'(out_valid), W'(model.size() > 0));
                if (model.size() > 0) chk("out_data", out_data, model[0]);
                chk("frame_err", W'(frame_err), W'(err_pend));
                chk("overflow", W'(overflow), W'(ovf_pend));
                if (frame_err) n_err_dut++;
                if (overflow) n_ovf_dut++;
                if (out_valid && out_ready) n_pop_dut++;
                if (model.size() > 0 && out_ready) void'(model.pop_front());
                err_pend = mark_err;
                ovf_pend = 1'b0;
                if (mark_push) begin
                    if (model.size() < 2) model.push_back(mark_word);
                    else ovf_pend = 1'b1;
                end
            end
        end
    end

    task automatic drive(input logic s, input logic b, input logic e,
                         input logic p, input logic [W-1:0] w, input logic er);
        serial_start = s;
        serial_out   = b;
        serial_end   = e;
        mark_push    = p;
        mark_word    = w;
        mark_err     = er;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned k = 0; k < n; k++)
            drive(1'b0, 1'($urandom), 1'($urandom), 1'b0, '0, 1'b0);
    endtask

    task automatic send_frame(input logic [W-1:0] word, input logic first_err);
        for (int i = W - 1; i >= 0; i--)
            drive(i == W - 1, word[i], i == 0, i == 0, word, first_err && (i == W - 1));
    endtask

    task automatic send_partial(input int unsigned n);
        for (int unsigned i = 0; i < n; i++)
            drive(i == 0, 1'($urandom), 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic send_early_end(input int unsigned n);
        for (int unsigned i = 0; i < n; i++)
            drive(i == 0, 1'($urandom), i == n - 1, 1'b0, '0, i == n - 1);
    endtask

    task automatic send_no_end();
        for (int unsigned i = 0; i < W; i++)
            drive(i == 0, 1'($urandom), 1'b0, 1'b0, '0, i == W - 1);
    endtask

    int unsigned e0, p0, o0;

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        serial_start = 1'b0;
        serial_out = 1'b0;
        serial_end = 1'b0;
        mark_push = 1'b0;
        mark_err = 1'b0;
        mark_word = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        p0 = n_pop_dut;
        send_frame(8'hD3, 1'b0);
        idle(3);
        chk("d3_words", W'(n_pop_dut - p0), W'(1));

        e0 = n_err_dut;
        send_frame(8'hA5, 1'b0);
        send_frame(8'h3C, 1'b0);
        idle(3);
        chk("b2b_errs", W'(n_err_dut - e0), W'(0));

        e0 = n_err_dut;
        send_early_end(5);
        send_frame(8'h81, 1'b0);
        idle(3);
        chk("early_end_errs", W'(n_err_dut - e0), W'(1));

        out_ready = 1'b0;
        o0 = n_ovf_dut;
        send_frame(8'h11, 1'b0);
        send_frame(8'h22, 1'b0);
        send_frame(8'h33, 1'b0);
        idle(2);
        chk("full_ovf", W'(n_ovf_dut - o0), W'(1));
        out_ready = 1'b1;
        p0 = n_pop_dut;
        idle(4);
        chk("drain_words", W'(n_pop_dut - p0), W'(2));

        e0 = n_err_dut;
        send_partial(3);
        send_frame(8'h5A, 1'b1);
        idle(3);
        chk("restart_errs", W'(n_err_dut - e0), W'(1));

        e0 = n_err_dut;
        send_partial(2);
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        rst = 1'b0;
        send_frame(8'hFF, 1'b0);
        idle(3);
        chk("rst_mid_errs", W'(n_err_dut - e0), W'(0));

        for (int unsigned it = 0; it < 300; it++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                6:       send_early_end($urandom_range(1, W - 1));
                7:       send_no_end();
                8: begin
                    send_partial($urandom_range(1, W - 1));
                    send_frame(W'($urandom), 1'b1);
                end
                9:       idle($urandom_range(0, 2));
                default: send_frame(W'($urandom), 1'b0);
            endcase
        end

        out_ready = 1'b1;
        for (int k = 0; k < 20 && model.size() > 0; k++) idle(1);
        idle(1);
        chk("final_drain", W'(model.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
